// File: rtl/mips32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips32_mem_arbiter
//
// Purpose:
//    Shares one single-port synchronous word memory between the three
//    requesters of the pipelined MIPS32 core: instruction fetch (IF stage),
//    data access (MEM stage, LW/SW) and a loader port that preloads code and
//    operands before the core runs. At most one access is granted per cycle.
//    The arbiter remembers who owns the in-flight read and steers the read
//    data back to that requester one cycle later. It also produces the IF
//    stall signal while a fetch is being held off.
//
// Configuration macro:
//    ARB_FAIR_EN - when defined, a starvation counter lets a waiting fetch
//                  win over data after STARVE_MAX consecutive data grants.
//                  When undefined, priority is strictly loader > data > fetch
//                  and no counter register exists.
//
// Parameters:
//    AW          word-address width
//    DW          data width
//    STARVE_MAX  data grants tolerated while a fetch waits (fair mode)
//
// Ports:
//    clk1        single clock, all state updates on the rising edge
//    rst_n       synchronous, active-low reset
//    halted      core HALTED flag, masks if_req while high
//    if_*        fetch request/address, grant, read-valid and read data
//    stall_if    holds the IF stage while an eligible fetch is not granted
//    dm_*        data request, store flag, address, store data, grant,
//                load-valid and load data
//    ld_*        loader write request, address, data and grant
//    mem_*       memory strobe, write enable, address, write data, read data
//                (mem_rdata is valid one cycle after a read strobe)
// ---------------------------------------------------------------------------
module mips32_mem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          halted,

   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   output logic          stall_if,

   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,

   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,

   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // Owner of the read that is currently in flight inside the memory.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   owner_e respOwner_q;
   owner_e respOwner_d;

   logic fetchEligible;
   logic boostFetch;
   logic ldGrant;
   logic dmGrant;
   logic ifGrant;

   // A negative starvation limit has no meaning; stop elaboration early.
   if (STARVE_MAX < 0) begin : g_starveMaxCheck
      $error("mips32_mem_arbiter: STARVE_MAX must be non-negative");
   end

   // A fetch only competes for the memory while the core is running.
   assign fetchEligible = if_req & ~halted;

`ifdef ARB_FAIR_EN
   // Counter range is 0..STARVE_MAX, so size it to hold STARVE_MAX itself.
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] StarveLimit = CW'(STARVE_MAX);

   logic [CW-1:0] starveCnt_q;
   logic [CW-1:0] starveCnt_d;

   // Once data has won STARVE_MAX times in a row against a waiting fetch,
   // the fetch is pushed ahead of data for one cycle. The loader is not
   // affected by this boost.
   assign boostFetch = fetchEligible & (starveCnt_q == StarveLimit);

   // Next value of the starvation counter. It only counts data grants
   // that actually overtook a waiting fetch; a loader grant leaves it
   // unchanged so a pending boost survives a preload write.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (ifGrant || !fetchEligible) begin
         starveCnt_d = '0;
      end else if (dmGrant && (starveCnt_q != StarveLimit)) begin
         starveCnt_d = starveCnt_q + 1'b1;
      end
   end

   // Starvation counter register, cleared by the synchronous reset.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end
`else
   // Strict priority: a fetch is never promoted above data.
   assign boostFetch = 1'b0;
`endif

   // Grant selection. Everything is suppressed while reset is asserted so
   // no memory access can slip through during reset. Otherwise the loader
   // always wins, a boosted fetch beats data, then data beats a normal fetch.
   always_comb begin
      ldGrant = 1'b0;
      dmGrant = 1'b0;
      ifGrant = 1'b0;
      if (rst_n) begin
         if (ld_req) begin
            ldGrant = 1'b1;
         end else if (boostFetch) begin
            ifGrant = 1'b1;
         end else if (dm_req) begin
            dmGrant = 1'b1;
         end else if (fetchEligible) begin
            ifGrant = 1'b1;
         end
      end
   end

   assign ld_gnt = ldGrant;
   assign dm_gnt = dmGrant;
   assign if_gnt = ifGrant;

   // A fetch that wants the memory but did not get it freezes IF.
   assign stall_if = rst_n & fetchEligible & ~ifGrant;

   // Memory port steering from the single winner. Address and write data
   // are driven to zero when nobody is granted to keep the bus quiet.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ldGrant) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (dmGrant) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (ifGrant) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end
   end

   // The owner for next cycle is whoever receives a read grant now. Writes
   // and idle cycles leave no owner, so they never produce an rvalid.
   always_comb begin
      respOwner_d = OWN_NONE;
      if (ifGrant) begin
         respOwner_d = OWN_IF;
      end else if (dmGrant && !dm_we) begin
         respOwner_d = OWN_DM;
      end
   end

   // Response owner register. Reset drops any read granted just before it,
   // so that read never reports valid data.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         respOwner_q <= OWN_NONE;
      end else begin
         respOwner_q <= respOwner_d;
      end
   end

   // Read return path. The rvalid is also masked by rst_n because the
   // owner register only clears on the edge that samples reset low, while
   // the memory data from a pre-reset read is already on mem_rdata.
   assign if_rvalid = rst_n & (respOwner_q == OWN_IF);
   assign dm_rvalid = rst_n & (respOwner_q == OWN_DM);

   // Read data is zero whenever the matching valid is low.
   assign if_rdata = if_rvalid ? mem_rdata : '0;
   assign dm_rdata = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips32_mem_arbiter
//
// Self-checking bench for mips32_mem_arbiter. It owns a synchronous word
// memory wired to the arbiter's memory port, keeps an independent model of
// who should win each cycle and what each read should return, runs a table
// of directed single-cycle vectors, a fairness run and a randomized run.
// ---------------------------------------------------------------------------
module tb_mips32_mem_arbiter;

   localparam int AW         = 10;
   localparam int DW         = 32;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 1 << AW;

   typedef struct {
      logic          rstN;
      logic          halted;
      logic          ifReq;
      logic [AW-1:0] ifAddr;
      logic          dmReq;
      logic          dmWe;
      logic [AW-1:0] dmAddr;
      logic [DW-1:0] dmWdata;
      logic          ldReq;
      logic [AW-1:0] ldAddr;
      logic [DW-1:0] ldWdata;
   } stim_t;

   // exp bits: {ldGnt, dmGnt, ifGnt, memEn, memWe, stallIf, ifRvalid, dmRvalid}
   typedef struct {
      stim_t         s;
      logic [7:0]    exp;
      logic [DW-1:0] expIfData;
      logic [DW-1:0] expDmData;
      string         name;
   } vec_t;

   logic          clk1 = 1'b0;
   logic          rstN;
   logic          halted;
   logic          ifReq;
   logic [AW-1:0] ifAddr;
   logic          ifGnt;
   logic          ifRvalid;
   logic [DW-1:0] ifRdata;
   logic          stallIf;
   logic          dmReq;
   logic          dmWe;
   logic [AW-1:0] dmAddr;
   logic [DW-1:0] dmWdata;
   logic          dmGnt;
   logic          dmRvalid;
   logic [DW-1:0] dmRdata;
   logic          ldReq;
   logic [AW-1:0] ldAddr;
   logic [DW-1:0] ldWdata;
   logic          ldGnt;
   logic          memEn;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWdata;
   logic [DW-1:0] memRdata;

   logic [DW-1:0] tbMem [0:DEPTH-1];
   logic [DW-1:0] memRdataReg = '0;
   logic          memLoad = 1'b1;

   // Reference model state
   logic [DW-1:0] shadow [0:DEPTH-1];
   int            mOwner;
   logic [DW-1:0] mPendData;
   int            mStarve;
   stim_t         cur;

   int total = 0;
   int bad = 0;
   int cycleNo = 0;

   vec_t tbl [16];

   // Free-running clock
   always #5 clk1 = ~clk1;

   mips32_mem_arbiter #(
      .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk1(clk1), .rst_n(rstN), .halted(halted),
      .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt),
      .if_rvalid(ifRvalid), .if_rdata(ifRdata), .stall_if(stallIf),
      .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
      .dm_gnt(dmGnt), .dm_rvalid(dmRvalid), .dm_rdata(dmRdata),
      .ld_req(ldReq), .ld_addr(ldAddr), .ld_wdata(ldWdata), .ld_gnt(ldGnt),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata)
   );

   // Single-port synchronous memory: read data appears one cycle after the strobe
   always @(posedge clk1) begin
      if (memLoad) begin
         for (int i = 0; i < DEPTH; i++) tbMem[i] <= initVal(i);
      end else if (memEn) begin
         if (memWe) tbMem[memAddr] <= memWdata;
         else       memRdataReg <= tbMem[memAddr];
      end
   end
   assign memRdata = memRdataReg;

   function automatic logic [DW-1:0] initVal(input int i);
      return (DW'(i) * 32'h0000_9E37) ^ 32'hC0DE_0000;
   endfunction

   function automatic stim_t mk(input logic r, input logic h,
                                input logic ir, input int ia,
                                input logic dr, input logic dw, input int da,
                                input logic [DW-1:0] dd,
                                input logic lr, input int la,
                                input logic [DW-1:0] ldd);
      stim_t s;
      s.rstN = r;   s.halted = h;
      s.ifReq = ir; s.ifAddr = AW'(ia);
      s.dmReq = dr; s.dmWe = dw; s.dmAddr = AW'(da); s.dmWdata = dd;
      s.ldReq = lr; s.ldAddr = AW'(la); s.ldWdata = ldd;
      return s;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] got,
                        input logic [DW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycleNo, got, want);
      end
   endtask

   // Drive one cycle's inputs shortly after the rising edge
   task automatic applyStimulus(input stim_t s);
      @(posedge clk1);
      #1;
      cycleNo++;
      cur     = s;
      rstN    = s.rstN;   halted  = s.halted;
      ifReq   = s.ifReq;  ifAddr  = s.ifAddr;
      dmReq   = s.dmReq;  dmWe    = s.dmWe;
      dmAddr  = s.dmAddr; dmWdata = s.dmWdata;
      ldReq   = s.ldReq;  ldAddr  = s.ldAddr; ldWdata = s.ldWdata;
   endtask

   // Compare all outputs against the model at the falling edge, then advance the model
   task automatic checkOutput();
      int            winner;
      bit            fetchElig;
      bit            boost;
      bit            expIfRv;
      bit            expDmRv;
      bit            expWe;
      @(negedge clk1);
      fetchElig = cur.ifReq && !cur.halted;
      boost     = 1'b0;
      winner    = 0;   // 0 none, 1 loader, 2 data, 3 fetch
      if (cur.rstN) begin
`ifdef ARB_FAIR_EN
         boost = fetchElig && (mStarve >= STARVE_MAX);
`endif
         if (cur.ldReq)       winner = 1;
         else if (boost)      winner = 3;
         else if (cur.dmReq)  winner = 2;
         else if (fetchElig)  winner = 3;
      end
      expIfRv = cur.rstN && (mOwner == 1);
      expDmRv = cur.rstN && (mOwner == 2);
      expWe   = (winner == 1) || ((winner == 2) && cur.dmWe);

      check("ldGnt", ldGnt, (winner == 1));
      check("dmGnt", dmGnt, (winner == 2));
      check("ifGnt", ifGnt, (winner == 3));
      check("memEn", memEn, (winner != 0));
      check("memWe", memWe, expWe);
      check("stallIf", stallIf, cur.rstN && fetchElig && (winner != 3));
      check("ifRvalid", ifRvalid, expIfRv);
      check("dmRvalid", dmRvalid, expDmRv);
      check("ifRdata", ifRdata, expIfRv ? mPendData : '0);
      check("dmRdata", dmRdata, expDmRv ? mPendData : '0);
      if (winner == 1) begin
         check("memAddrLd", memAddr, cur.ldAddr);
         check("memWdataLd", memWdata, cur.ldWdata);
      end else if (winner == 2) begin
         check("memAddrDm", memAddr, cur.dmAddr);
         if (cur.dmWe) check("memWdataDm", memWdata, cur.dmWdata);
      end else if (winner == 3) begin
         check("memAddrIf", memAddr, cur.ifAddr);
      end

      if (!cur.rstN) begin
         mOwner  = 0;
         mStarve = 0;
      end else begin
         mOwner = 0;
         if (winner == 3) begin
            mOwner    = 1;
            mPendData = shadow[cur.ifAddr];
         end else if (winner == 2 && !cur.dmWe) begin
            mOwner    = 2;
            mPendData = shadow[cur.dmAddr];
         end
         if (winner == 1) shadow[cur.ldAddr] = cur.ldWdata;
         if (winner == 2 && cur.dmWe) shadow[cur.dmAddr] = cur.dmWdata;
         if (winner == 3 || !fetchElig) mStarve = 0;
         else if (winner == 2 && mStarve < STARVE_MAX) mStarve++;
      end
   endtask

   // Compare against the hand-derived expectations stored in a table row
   task automatic checkTable(input vec_t v);
      check({v.name, ".ldGnt"},   ldGnt,    v.exp[7]);
      check({v.name, ".dmGnt"},   dmGnt,    v.exp[6]);
      check({v.name, ".ifGnt"},   ifGnt,    v.exp[5]);
      check({v.name, ".memEn"},   memEn,    v.exp[4]);
      check({v.name, ".memWe"},   memWe,    v.exp[3]);
      check({v.name, ".stallIf"}, stallIf,  v.exp[2]);
      check({v.name, ".ifRv"},    ifRvalid, v.exp[1]);
      check({v.name, ".dmRv"},    dmRvalid, v.exp[0]);
      check({v.name, ".ifData"},  ifRdata,  v.expIfData);
      check({v.name, ".dmData"},  dmRdata,  v.expDmData);
   endtask

   initial begin
      int ifCount;
      int expIfCount;
      stim_t s;

      for (int i = 0; i < DEPTH; i++) shadow[i] = initVal(i);
      mOwner = 0; mStarve = 0; mPendData = '0;
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rstN = 0; halted = 0; ifReq = 0; ifAddr = '0;
      dmReq = 0; dmWe = 0; dmAddr = '0; dmWdata = '0;
      ldReq = 0; ldAddr = '0; ldWdata = '0;

      //              rst h  ifR ifA  dmR we dmA  dmD   ldR ldA  ldD
      tbl[0]  = '{mk(0, 0, 1,  5,   1, 0, 1,   0,    1,  2,   9), 8'b000_00_0_00, '0, '0, "rst0"};
      tbl[1]  = '{mk(0, 0, 1,  5,   1, 0, 1,   0,    1,  2,   9), 8'b000_00_0_00, '0, '0, "rst1"};
      tbl[2]  = '{mk(1, 0, 1,  5,   0, 0, 0,   0,    0,  0,   0), 8'b001_10_0_00, '0, '0, "if5"};
      tbl[3]  = '{mk(1, 0, 0,  0,   0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_10, initVal(5), '0, "if5rv"};
      tbl[4]  = '{mk(1, 0, 1,  200, 0, 0, 0,   0,    1,  200, 7), 8'b100_11_1_00, '0, '0, "ld200"};
      tbl[5]  = '{mk(1, 0, 1,  200, 0, 0, 0,   0,    0,  0,   0), 8'b001_10_0_00, '0, '0, "if200"};
      tbl[6]  = '{mk(1, 0, 0,  0,   1, 1, 198, 5040, 0,  0,   0), 8'b010_11_0_10, 32'd7, '0, "sw198"};
      tbl[7]  = '{mk(1, 0, 0,  0,   1, 0, 198, 0,    0,  0,   0), 8'b010_10_0_00, '0, '0, "lw198"};
      tbl[8]  = '{mk(1, 0, 0,  0,   0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_01, '0, 32'd5040, "lw198rv"};
      tbl[9]  = '{mk(1, 1, 1,  3,   0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_00, '0, '0, "halt"};
      tbl[10] = '{mk(1, 0, 1,  11,  1, 0, 10,  0,    0,  0,   0), 8'b010_10_1_00, '0, '0, "dmif"};
      tbl[11] = '{mk(1, 0, 1,  11,  0, 0, 0,   0,    0,  0,   0), 8'b001_10_0_01, '0, initVal(10), "ifonly"};
      tbl[12] = '{mk(1, 0, 1,  12,  0, 0, 0,   0,    0,  0,   0), 8'b001_10_0_10, initVal(11), '0, "b2b"};
      tbl[13] = '{mk(0, 0, 1,  13,  0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_00, '0, '0, "rstmid"};
      tbl[14] = '{mk(1, 0, 0,  0,   0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_00, '0, '0, "post"};
      tbl[15] = '{mk(1, 0, 0,  0,   0, 0, 0,   0,    0,  0,   0), 8'b000_00_0_00, '0, '0, "idle"};

      @(posedge clk1);
      #1 memLoad = 1'b0;

      $display("[TB] directed table");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i].s);
         checkOutput();
         checkTable(tbl[i]);
      end

      $display("[TB] fairness run");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput();
      ifCount = 0;
      for (int k = 0; k < 15; k++) begin
         applyStimulus(mk(1, 0, 1, 40 + k, 1, 0, 20 + k, 0, 0, 0, 0));
         checkOutput();
         if (ifGnt) ifCount++;
      end
`ifdef ARB_FAIR_EN
      expIfCount = 3;
`else
      expIfCount = 0;
`endif
      check("fairIfCount", ifCount, expIfCount);

      $display("[TB] random run");
      for (int k = 0; k < 400; k++) begin
         s.rstN    = ($urandom_range(0, 39) != 0);
         s.halted  = ($urandom_range(0, 7) == 0);
         s.ifReq   = $urandom_range(0, 1);
         s.ifAddr  = AW'($urandom_range(0, 15));
         s.dmReq   = $urandom_range(0, 1);
         s.dmWe    = $urandom_range(0, 1);
         s.dmAddr  = AW'($urandom_range(0, 15));
         s.dmWdata = $urandom;
         s.ldReq   = ($urandom_range(0, 5) == 0);
         s.ldAddr  = AW'($urandom_range(0, 15));
         s.ldWdata = $urandom;
         applyStimulus(s);
         checkOutput();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
